// File: rtl/ap_seq_ctrl.sv
// Aging-pattern sequencer: steps AP Mode through a masked pattern set, N frames each, for a set loop count.
// Latency: all outputs registered; Mode/enable change on the clk edge that sees the vsync leading edge.
// Backpressure: none; start/stop are 1-cycle pulses, start ignored while busy. Watchdog: `AP_SEQ_TIMEOUT_EN.
module ap_seq_ctrl #(
    parameter bit VS_POL = 1'b1,
    parameter int CNT_W  = 8,
    parameter int LOOP_W = 8
`ifdef AP_SEQ_TIMEOUT_EN
    ,
    parameter int TO_CYC = 2_000_000
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [15:0]       pat_mask,
    input  logic [CNT_W-1:0]  dwell_frames,
    input  logic [LOOP_W-1:0] loops,
    input  logic              DPi_vs,
    output logic              enable,
    output logic [3:0]        Mode,
    output logic              busy,
    output logic              done,
    output logic [LOOP_W-1:0] loop_cnt,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t            state_q, state_d;

    logic              vs_d;
    logic              vs_edge;
    logic [15:0]       mask_q;
    logic [CNT_W-1:0]  dwell_q, dwell_lim;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [LOOP_W-1:0] loops_q, loop_cnt_q, loop_cnt_d, loop_cnt_inc;
    logic [3:0]        mode_q, mode_d;
    logic [3:0]        start_bit, lo_bit, nx_bit;
    logic              nx_found;
    logic              enable_q, enable_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              stop_pend_q, stop_pend_d;
    logic              acc_start, stop_now, dwell_end, pass_end, last_loop, timeout;

    // Index of the lowest set bit (0 when the mask is empty).
    function automatic logic [3:0] lowest_bit(input logic [15:0] m);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (m[i]) r = 4'(i);
        end
        return r;
    endfunction

    assign vs_edge   = (DPi_vs == VS_POL) && (vs_d != VS_POL);
    assign start_bit = lowest_bit(pat_mask);
    assign lo_bit    = lowest_bit(mask_q);

    // Next pattern: lowest set bit strictly above the current Mode; nx_found=0 means wrap.
    always_comb begin
        nx_bit   = lo_bit;
        nx_found = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (mask_q[i] && (i > int'(mode_q))) begin
                nx_bit   = 4'(i);
                nx_found = 1'b1;
            end
        end
    end

    assign acc_start    = start && (pat_mask != 16'h0000) &&
                          ((state_q == S_IDLE) || (state_q == S_ERR));
    assign dwell_lim    = (dwell_q == '0) ? '0 : dwell_q - CNT_W'(1);
    assign dwell_end    = (frame_cnt_q == dwell_lim);
    assign pass_end     = dwell_end && !nx_found;
    assign loop_cnt_inc = loop_cnt_q + LOOP_W'(1);
    assign last_loop    = (loops_q != '0) && (loop_cnt_inc == loops_q);
    assign stop_now     = stop || stop_pend_q;

`ifdef AP_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TO_CYC + 1);
    logic [TO_W-1:0] to_cnt_q;

    // Watchdog: counts cycles since the last vsync edge while armed or running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else if (vs_edge || !((state_q == S_ARM) || (state_q == S_RUN))) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end
    end

    assign timeout = ((state_q == S_ARM) || (state_q == S_RUN)) && !vs_edge &&
                     (to_cnt_q == TO_W'(TO_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state: ARM waits for the first frame, RUN leaves on a stop or on the last pass.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (acc_start) state_d = S_ARM;
            S_ARM: begin
                if (timeout)      state_d = S_ERR;
                else if (stop)    state_d = S_IDLE;
                else if (vs_edge) state_d = S_RUN;
            end
            S_RUN: begin
                if (timeout) state_d = S_ERR;
                else if (vs_edge && (stop_now || (pass_end && last_loop))) state_d = S_IDLE;
            end
            S_ERR:   if (acc_start) state_d = S_ARM;
            default: state_d = S_IDLE;
        endcase
    end

    // Output/datapath next values; Mode only moves on an accepted start or a frame boundary.
    always_comb begin
        mode_d      = mode_q;
        frame_cnt_d = frame_cnt_q;
        loop_cnt_d  = loop_cnt_q;
        done_d      = 1'b0;
        stop_pend_d = 1'b0;
        enable_d    = (state_d == S_RUN);
        busy_d      = (state_d == S_ARM) || (state_d == S_RUN);
        err_d       = (state_d == S_ERR);
        if (acc_start) begin
            mode_d      = start_bit;
            frame_cnt_d = '0;
            loop_cnt_d  = '0;
        end else if ((state_q == S_ARM) && vs_edge) begin
            frame_cnt_d = '0;
        end else if ((state_q == S_RUN) && vs_edge && !stop_now) begin
            if (dwell_end) begin
                frame_cnt_d = '0;
                if (pass_end) begin
                    loop_cnt_d = loop_cnt_inc;
                    if (last_loop) done_d = 1'b1;   // Mode keeps the last pattern shown
                    else           mode_d = lo_bit;
                end else begin
                    mode_d = nx_bit;
                end
            end else begin
                frame_cnt_d = frame_cnt_q + CNT_W'(1);
            end
        end
        // A stop seen mid-frame is held until the next boundary.
        if ((state_q == S_RUN) && (state_d == S_RUN)) stop_pend_d = stop_pend_q | stop;
    end

    // Registered outputs, counters and the run configuration captured on start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d        <= 1'b0;
            mask_q      <= '0;
            dwell_q     <= '0;
            loops_q     <= '0;
            frame_cnt_q <= '0;
            loop_cnt_q  <= '0;
            mode_q      <= '0;
            enable_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            stop_pend_q <= 1'b0;
        end else begin
            vs_d        <= DPi_vs;
            if (acc_start) begin
                mask_q  <= pat_mask;
                dwell_q <= dwell_frames;
                loops_q <= loops;
            end
            frame_cnt_q <= frame_cnt_d;
            loop_cnt_q  <= loop_cnt_d;
            mode_q      <= mode_d;
            enable_q    <= enable_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            stop_pend_q <= stop_pend_d;
        end
    end

    assign enable   = enable_q;
    assign Mode     = mode_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign loop_cnt = loop_cnt_q;
    assign err      = err_q;

endmodule

// File: tb/tb_ap_seq_ctrl.sv
// Testbench for ap_seq_ctrl: fixed vector table, hand sequences for stop/reset corners,
// and randomized runs checked against a frame-index model of the pattern schedule.
// Inputs driven just after the falling edge, outputs sampled on the falling edge.
module tb_ap_seq_ctrl;

    logic        clk, clk_run, rst_n;
    logic        start, stop, DPi_vs;
    logic [15:0] pat_mask;
    logic [7:0]  dwell_frames, loops;
    logic        enable, busy, done, err;
    logic [3:0]  Mode;
    logic [7:0]  loop_cnt;

    int vec_cnt = 0;
    int mis_cnt = 0;

    ap_seq_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .pat_mask     (pat_mask),
        .dwell_frames (dwell_frames),
        .loops        (loops),
        .DPi_vs       (DPi_vs),
        .enable       (enable),
        .Mode         (Mode),
        .busy         (busy),
        .done         (done),
        .loop_cnt     (loop_cnt),
        .err          (err)
    );

    initial begin
        clk     = 1'b0;
        clk_run = 1'b1;
        forever begin
            #5;
            if (clk_run) clk = ~clk;
        end
    end

    typedef struct {
        logic [15:0] mask;
        int          dwell;
        int          lps;
        int          edges;
        int          mode;
        int          en;
        int          bsy;
        int          dones;
        int          lc;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            mis_cnt++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        start  = 1'b0;
        stop   = 1'b0;
        DPi_vs = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
    endtask

    task automatic do_start(input logic [15:0] m, input int d, input int l);
        pat_mask     = m;
        dwell_frames = 8'(d);
        loops        = 8'(l);
        start        = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    // One-cycle vsync pulse; returns on the falling edge right after the edge is seen.
    task automatic vs_pulse();
        DPi_vs = 1'b1;
        cyc(1);
        DPi_vs = 1'b0;
    endtask

    initial begin
        int          dones;
        logic [15:0] m;
        int          d, l, n, dd, total, stop_e, f, exp_mode, exp_lc, gap;
        bit          do_stop, fin;
        int          lst[$];

        pat_mask     = '0;
        dwell_frames = '0;
        loops        = '0;
        do_reset();

        // Reset state
        chk("reset_enable", enable, 0);
        chk("reset_mode", Mode, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_loop_cnt", loop_cnt, 0);
        chk("reset_err", err, 0);

        //             mask      dw lp ed mode en bsy dn lc
        tbl[0] = '{16'h0005, 2, 1, 5, 2,  0, 0, 1, 1};
        tbl[1] = '{16'h8001, 0, 0, 3, 0,  1, 1, 0, 1};
        tbl[2] = '{16'h8001, 0, 0, 2, 15, 1, 1, 0, 0};
        tbl[3] = '{16'h0010, 1, 2, 3, 4,  0, 0, 1, 2};
        tbl[4] = '{16'h0102, 3, 1, 4, 8,  1, 1, 0, 0};
        tbl[5] = '{16'h0102, 3, 1, 7, 8,  0, 0, 1, 1};
        tbl[6] = '{16'h0000, 1, 1, 3, 0,  0, 0, 0, 0};
        tbl[7] = '{16'h0006, 1, 2, 5, 2,  0, 0, 1, 2};
        tbl[8] = '{16'h0006, 1, 2, 0, 1,  0, 1, 0, 0};

        for (int r = 0; r < 9; r++) begin
            do_reset();
            do_start(tbl[r].mask, tbl[r].dwell, tbl[r].lps);
            dones = 0;
            for (int e = 0; e < tbl[r].edges; e++) begin
                vs_pulse();
                if (done === 1'b1) dones++;
                cyc(2);
            end
            chk($sformatf("tbl%0d_mode", r), Mode, tbl[r].mode);
            chk($sformatf("tbl%0d_enable", r), enable, tbl[r].en);
            chk($sformatf("tbl%0d_busy", r), busy, tbl[r].bsy);
            chk($sformatf("tbl%0d_done_pulses", r), dones, tbl[r].dones);
            chk($sformatf("tbl%0d_loop_cnt", r), loop_cnt, tbl[r].lc);
        end

        // Stop mid-frame: enable holds until the next boundary, no done
        do_reset();
        do_start(16'h0003, 1, 0);
        vs_pulse();
        cyc(2);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        chk("stop_mid_enable_held", enable, 1);
        cyc(3);
        chk("stop_mid_busy_held", busy, 1);
        vs_pulse();
        chk("stop_mid_enable", enable, 0);
        chk("stop_mid_busy", busy, 0);
        chk("stop_mid_done", done, 0);
        chk("stop_mid_mode", Mode, 0);
        cyc(2);
        chk("stop_mid_done_after", done, 0);

        // Stop in ARM goes straight to IDLE
        do_start(16'h0004, 1, 0);
        chk("arm_mode", Mode, 2);
        chk("arm_busy", busy, 1);
        chk("arm_enable", enable, 0);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        chk("arm_stop_busy", busy, 0);
        vs_pulse();
        chk("arm_stop_no_run", enable, 0);
        cyc(2);

        // Stop in the same cycle as the vsync edge takes effect on that edge
        do_start(16'h0003, 1, 0);
        vs_pulse();
        cyc(2);
        stop   = 1'b1;
        DPi_vs = 1'b1;
        cyc(1);
        stop   = 1'b0;
        DPi_vs = 1'b0;
        chk("stop_edge_enable", enable, 0);
        chk("stop_edge_busy", busy, 0);
        chk("stop_edge_mode", Mode, 0);
        cyc(2);

        // Start while running is ignored
        do_start(16'h0003, 1, 0);
        vs_pulse();
        cyc(1);
        do_start(16'h0100, 1, 1);
        chk("run_start_ignored_mode", Mode, 0);
        chk("run_start_ignored_busy", busy, 1);
        vs_pulse();
        chk("run_start_ignored_next", Mode, 1);
        cyc(2);

        // Asynchronous reset mid-run with the clock stopped
        do_reset();
        do_start(16'h0006, 0, 0);
        for (int e = 0; e < 3; e++) begin
            vs_pulse();
            cyc(1);
        end
        chk("pre_rst_loop_cnt", loop_cnt, 1);
        chk("pre_rst_mode", Mode, 1);
        clk_run = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_enable", enable, 0);
        chk("async_rst_mode", Mode, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_loop_cnt", loop_cnt, 0);
        #1 rst_n = 1'b1;
        clk_run = 1'b1;
        cyc(2);

        // Randomized runs against the frame-index schedule model
        for (int it = 0; it < 30; it++) begin
            m = 16'($urandom) & 16'($urandom);
            if (m == 16'h0000) m = 16'(1) << $urandom_range(0, 15);
            d = $urandom_range(0, 3);
            l = $urandom_range(0, 3);
            lst.delete();
            for (int i = 0; i < 16; i++) if (m[i]) lst.push_back(i);
            n       = lst.size();
            dd      = (d == 0) ? 1 : d;
            total   = (l == 0) ? -1 : n * dd * l;
            do_stop = (l == 0) || ($urandom_range(0, 1) == 1);
            stop_e  = do_stop ? $urandom_range(1, (l == 0) ? 2 * n * dd + 2 : total) : 0;

            do_start(m, d, l);
            chk("rnd_arm_mode", Mode, lst[0]);
            chk("rnd_arm_busy", busy, 1);
            chk("rnd_arm_enable", enable, 0);
            exp_mode = lst[0];
            exp_lc   = 0;
            fin      = 1'b0;
            for (int k = 1; k <= 1000 && !fin; k++) begin
                vs_pulse();
                f = k - 1;
                if (do_stop && (k == stop_e + 1)) begin
                    fin = 1'b1;
                    chk("rnd_stop_enable", enable, 0);
                    chk("rnd_stop_busy", busy, 0);
                    chk("rnd_stop_done", done, 0);
                    chk("rnd_stop_mode", Mode, exp_mode);
                    chk("rnd_stop_loop_cnt", loop_cnt, exp_lc);
                end else if ((total >= 0) && (f == total)) begin
                    fin = 1'b1;
                    chk("rnd_end_enable", enable, 0);
                    chk("rnd_end_busy", busy, 0);
                    chk("rnd_end_done", done, 1);
                    chk("rnd_end_mode", Mode, lst[n-1]);
                    chk("rnd_end_loop_cnt", loop_cnt, l);
                end else begin
                    exp_mode = lst[(f / dd) % n];
                    exp_lc   = f / (n * dd);
                    chk("rnd_mode", Mode, exp_mode);
                    chk("rnd_enable", enable, 1);
                    chk("rnd_busy", busy, 1);
                    chk("rnd_done", done, 0);
                    chk("rnd_loop_cnt", loop_cnt, exp_lc);
                end
                gap = $urandom_range(1, 3);
                if (!fin && do_stop && (k == stop_e)) begin
                    stop = 1'b1;
                    cyc(1);
                    stop = 1'b0;
                    chk("rnd_stop_pending_enable", enable, 1);
                end
                cyc(gap);
            end
            if (!fin) chk("rnd_run_terminated", 0, 1);
            chk("rnd_done_cleared", done, 0);
            chk("rnd_err", err, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
        $finish;
    end

endmodule
